// File: rtl/spi_frame_master.sv
// SPI master for the 10-bit command frame protocol (idle-low, check bit, 10 frame bits, tail, optional read).
// Optional define SPI_FRAME_MASTER_SEQ_CHECK_EN rejects reads issued before an address load.
module spi_frame_master #(
  parameter int unsigned RD_WAIT = 3,
  parameter int unsigned GAP     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       seq_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_CMD   = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_TAIL  = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_READ  = 3'd6;
  localparam logic [2:0] S_GAP   = 3'd7;

  localparam logic [3:0] RD_WAIT_LAST = 4'(RD_WAIT - 1);
  localparam logic [3:0] GAP_LAST     = 4'(GAP - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] sh_q, sh_d;
  logic [1:0] op_q, op_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic       rd_win_q, rd_last_q;
  logic [7:0] rx_q, rd_data_q;
  logic       rd_valid_q;
  logic       accept;
  logic       skip;

  assign accept = cmd_valid & (state_q == S_IDLE);

`ifdef SPI_FRAME_MASTER_SEQ_CHECK_EN
  logic addr_loaded_q;
  logic err_pend_q;
  logic seq_err_q;

  assign skip = accept & (cmd_data[9:8] == 2'b11) & ~addr_loaded_q;

  // Address-loaded tracking and one-cycle sequence error pulse (lands at E+1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_loaded_q <= 1'b0;
      err_pend_q    <= 1'b0;
      seq_err_q     <= 1'b0;
    end else begin
      err_pend_q <= skip;
      seq_err_q  <= err_pend_q;
      if ((state_q == S_TAIL) && (op_q == 2'b10)) begin
        addr_loaded_q <= 1'b1;
      end else if ((state_q == S_READ) && (cnt_q == 4'd7)) begin
        addr_loaded_q <= 1'b0;
      end else begin
        addr_loaded_q <= addr_loaded_q;
      end
    end
  end

  assign seq_err = seq_err_q;
`else
  assign skip    = 1'b0;
  assign seq_err = 1'b0;
`endif

  // Next-state, counter and frame shifter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sh_d    = cmd_data;
          op_d    = cmd_data[9:8];
          cnt_d   = 4'd0;
          state_d = skip ? S_GAP : S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: state_d = S_CMD;
      S_CMD: begin
        state_d = S_SHIFT;
        cnt_d   = 4'd0;
      end
      S_SHIFT: begin
        sh_d = {sh_q[8:0], 1'b0};
        if (cnt_q == 4'd9) begin
          state_d = S_TAIL;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_TAIL: begin
        cnt_d   = 4'd0;
        state_d = (op_q == 2'b11) ? S_WAIT : S_GAP;
      end
      S_WAIT: begin
        if (cnt_q == RD_WAIT_LAST) begin
          state_d = S_READ;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_READ: begin
        if (cnt_q == 4'd7) begin
          state_d = S_GAP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Pin values follow the state one cycle later, so SS_n falls at E+1.
  always_comb begin
    ss_n_d = (state_q == S_IDLE) || (state_q == S_GAP);
    case (state_q)
      S_CMD, S_SHIFT: mosi_d = sh_q[9];
      default:        mosi_d = 1'b0;
    endcase
  end

  // State, pin registers and MISO deserialiser aligned with the pin-level READ window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      sh_q       <= 10'd0;
      op_q       <= 2'b00;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rd_win_q   <= 1'b0;
      rd_last_q  <= 1'b0;
      rx_q       <= 8'h00;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      op_q       <= op_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      rd_win_q   <= (state_q == S_READ);
      rd_last_q  <= (state_q == S_READ) && (cnt_q == 4'd7);
      rd_valid_q <= rd_last_q;
      if (rd_win_q) begin
        rx_q <= {rx_q[6:0], MISO};
      end
      if (rd_last_q) begin
        rd_data_q <= {rx_q[6:0], MISO};
      end
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master: writes, back-to-back gap, read, async reset, sequence check.
module tb_spi_frame_master;

  localparam int RDW = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] cmd_data = 10'd0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       ss_n;
  logic       mosi;
  logic       miso = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       seq_err;

  int  n_vec = 0;
  int  n_err = 0;
  bit  seen_err = 1'b0;
  int  hi;

  spi_frame_master #(.RD_WAIT(3), .GAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .SS_n(ss_n), .MOSI(mosi), .MISO(miso),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (seq_err === 1'b1) seen_err = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one frame from the current negedge: counts SS_n-high cycles, checks MOSI and SS_n-low length.
  task automatic run_frame(input string tag, input logic [12:0] exp_mosi, input int exp_low,
                           input bit is_rd, input logic [7:0] byte_v, input bit drop_valid,
                           output int hi_cnt);
    int n;
    hi_cnt = 0;
    while (ss_n === 1'b1 && hi_cnt < 50) begin
      hi_cnt++;
      @(negedge clk);
    end
    check({tag, "_select"}, 32'(hi_cnt < 50), 32'd1);
    n = 0;
    while (ss_n === 1'b0 && n < 60) begin
      if (drop_valid && n == 0) begin
        cmd_valid = 1'b0;
        cmd_data  = 10'h3FF;
      end
      if (n < 13) check($sformatf("%s_mosi%0d", tag, n), 32'(mosi), 32'(exp_mosi[12-n]));
      if (is_rd && n >= 13 + RDW && n < 21 + RDW) miso = byte_v[7-(n-13-RDW)];
      else miso = 1'b0;
      n++;
      @(negedge clk);
    end
    miso = 1'b0;
    check({tag, "_low_len"}, 32'(n), 32'(exp_low));
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'(is_rd));
    if (is_rd) check({tag, "_rd_data"}, 32'(rd_data), 32'(byte_v));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ss_n", 32'(ss_n), 32'd1);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_seq_err", 32'(seq_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    do_reset();

    // Write address then write data with cmd_valid held high across both frames.
    cmd_valid = 1'b1;
    cmd_data  = 10'h03C;
    @(negedge clk);
    check("wa_busy_after_accept", 32'(busy), 32'd1);
    check("wa_ss_n_start_cycle", 32'(ss_n), 32'd1);
    cmd_data = 10'h1A5;
    run_frame("wa", 13'b0000001111000, 13, 1'b0, 8'h00, 1'b0, hi);
    run_frame("wd", 13'b0001101001010, 13, 1'b0, 8'h00, 1'b1, hi);
    check("wd_gap_high", 32'(hi), 32'd3);
    repeat (5) @(negedge clk);
    check("wd_no_dup_ss_n", 32'(ss_n), 32'd1);
    check("wd_no_dup_busy", 32'(busy), 32'd0);

    // Address load then read-data with slave returning 8'hC3.
    cmd_valid = 1'b1;
    cmd_data  = 10'h2A5;
    run_frame("ra", 13'b0110101001010, 13, 1'b0, 8'h00, 1'b1, hi);
    cmd_valid = 1'b1;
    cmd_data  = 10'h300;
    run_frame("rd", 13'b0111000000000, 24, 1'b1, 8'hC3, 1'b1, hi);
    @(negedge clk);
    check("rd_valid_pulse_end", 32'(rd_valid), 32'd0);
    check("rd_data_hold", 32'(rd_data), 32'hC3);
    repeat (4) @(negedge clk);

    // Asynchronous reset at the 5th SHIFT cycle of a write.
    cmd_valid = 1'b1;
    cmd_data  = 10'h03C;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 10 && ss_n !== 1'b0; k++) @(negedge clk);
    check("ar_select", 32'(ss_n), 32'd0);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_ss_n", 32'(ss_n), 32'd1);
    check("ar_mosi", 32'(mosi), 32'd0);
    check("ar_rd_data", 32'(rd_data), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_ready", 32'(cmd_ready), 32'd1);
    check("ar_no_rd_valid", 32'(rd_valid), 32'd0);
    cmd_valid = 1'b1;
    cmd_data  = 10'h03C;
    run_frame("ar_wa", 13'b0000001111000, 13, 1'b0, 8'h00, 1'b1, hi);
    repeat (4) @(negedge clk);

    // Read-data command with no prior address load.
    do_reset();
    cmd_valid = 1'b1;
    cmd_data  = 10'h3FF;
`ifdef SPI_FRAME_MASTER_SEQ_CHECK_EN
    @(negedge clk);
    cmd_valid = 1'b0;
    check("sq_err_e0", 32'(seq_err), 32'd0);
    check("sq_busy_e0", 32'(busy), 32'd1);
    @(negedge clk);
    check("sq_err_e1", 32'(seq_err), 32'd1);
    check("sq_busy_e1", 32'(busy), 32'd1);
    @(negedge clk);
    check("sq_err_e2", 32'(seq_err), 32'd0);
    check("sq_idle_e2", 32'(cmd_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("sq_ss_n_%0d", k), 32'(ss_n), 32'd1);
      @(negedge clk);
    end
    check("sq_seen_err", 32'(seen_err), 32'd1);
`else
    run_frame("sq", 13'b0111111111110, 24, 1'b1, 8'h00, 1'b1, hi);
    repeat (3) @(negedge clk);
    check("sq_seen_err", 32'(seen_err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
